// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives a single-cycle instruction memory,
// and presents each fetched word through a one-entry valid/ready output stage.
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [31:0] TEXT_LIMIT = 32'h0040_0400
) (
  input  logic        clock,
  input  logic        clear,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {FETCH, FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        valid_next;
  logic [31:0] instr_next, opc_next, fpc_next, count_next;
  logic        stage_free, pc_legal;

  assign imem_addr = pc;
  assign fault     = (state == FAULT);

  assign stage_free = !out_valid || out_ready;
  assign pc_legal   = (pc >= TEXT_BASE) && (pc < TEXT_LIMIT) && (pc[1:0] == 2'b00);

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      out_valid   <= valid_next;
      out_instr   <= instr_next;
      out_pc      <= opc_next;
      fault_pc    <= fpc_next;
      fetch_count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = out_valid;
    instr_next = out_instr;
    opc_next   = out_pc;
    fpc_next   = fault_pc;
    count_next = fetch_count;

    // A redirect flushes the stage, so a simultaneous handshake is not counted.
    if (out_valid && out_ready && !redirect_valid)
      count_next = fetch_count + 32'd1;

    if (redirect_valid) begin
      pc_next    = redirect_target;
      valid_next = 1'b0;
      state_next = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          // Legality is only evaluated when the stage can accept a new word.
          if (stage_free) begin
            if (pc_legal) begin
              instr_next = imem_instr;
              opc_next   = pc;
              valid_next = 1'b1;
              pc_next    = pc + 32'd4;
            end else begin
              state_next = FAULT;
              fpc_next   = pc;
              valid_next = 1'b0;
            end
          end
        end
        FAULT: valid_next = 1'b0;
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch_controller;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam logic [31:0] LIMIT = 32'h0040_0400;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mem [256];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_opc, m_fpc, m_count;
  logic        m_valid, m_fault;

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (addr >= BASE && addr < LIMIT) return mem[off[9:2]];
    return 32'hBAD0_0000 ^ addr;
  endfunction

  assign imem_instr = word_at(imem_addr);

  instruction_fetch_controller #(
    .RESET_PC  (32'h0040_0000),
    .TEXT_BASE (BASE),
    .TEXT_LIMIT(LIMIT)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the rules of the fetch stage.
  task automatic model_step(input logic clr, input logic rv, input logic [31:0] rt, input logic rdy);
    logic legal;
    legal = (m_pc >= BASE) && (m_pc < LIMIT) && (m_pc % 4 == 0);
    if (clr) begin
      m_pc = BASE; m_valid = 0; m_instr = 0; m_opc = 0;
      m_fault = 0; m_fpc = 0; m_count = 0;
    end else if (rv) begin
      m_pc = rt; m_valid = 0; m_fault = 0;
    end else begin
      if (m_valid && rdy) m_count = m_count + 1;
      if (!m_fault && (!m_valid || rdy)) begin
        if (legal) begin
          m_instr = word_at(m_pc); m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
        end else begin
          m_fault = 1; m_fpc = m_pc; m_valid = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic clr, input logic rv, input logic [31:0] rt, input logic rdy);
    @(negedge clock);
    clear = clr; redirect_valid = rv; redirect_target = rt; out_ready = rdy;
    model_step(clr, rv, rt, rdy);
    @(posedge clock);
    #1;
    check_eq("imem_addr",   imem_addr,   m_pc);
    check_eq("out_valid",   {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("fault",       {31'd0, fault},     {31'd0, m_fault});
    check_eq("fault_pc",    fault_pc,    m_fpc);
    check_eq("fetch_count", fetch_count, m_count);
    if (m_valid) begin
      check_eq("out_instr", out_instr, m_instr);
      check_eq("out_pc",    out_pc,    m_opc);
    end else if (clr) begin
      check_eq("out_instr_rst", out_instr, 32'h0);
      check_eq("out_pc_rst",    out_pc,    32'h0);
    end
  endtask

  function automatic logic [31:0] pick_target();
    int unsigned sel;
    sel = $urandom_range(9, 0);
    if (sel < 5) return BASE + 4 * $urandom_range(255, 0);
    if (sel < 7) return LIMIT - 4 * $urandom_range(4, 1);
    if (sel < 8) return (BASE + 4 * $urandom_range(255, 0)) | 32'(1 + $urandom_range(2, 0));
    if (sel < 9) return 32'($urandom_range(32'h003F_FFFF, 0));
    return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0022_1820;
    mem[1] = 32'h0022_1822;

    // Reset and sequential fetch
    cycle(1, 0, '0, 1);
    check_eq("rst_addr", imem_addr, 32'h0040_0000);
    cycle(0, 0, '0, 1);
    check_eq("seq0_pc",    out_pc,    32'h0040_0000);
    check_eq("seq0_instr", out_instr, 32'h0022_1820);
    cycle(0, 0, '0, 1);
    check_eq("seq1_pc",    out_pc,    32'h0040_0004);
    check_eq("seq1_instr", out_instr, 32'h0022_1822);
    cycle(0, 0, '0, 1);
    check_eq("seq_count", fetch_count, 32'd2);

    // Backpressure for three cycles
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0);
    check_eq("bp_pc",    out_pc,      32'h0040_0008);
    check_eq("bp_count", fetch_count, 32'd2);
    cycle(0, 0, '0, 1);
    check_eq("bp_release", fetch_count, 32'd3);

    // Redirect flush during a handshake
    cycle(0, 1, BASE, 1);
    check_eq("flush_count", fetch_count, 32'd3);
    cycle(0, 0, '0, 1);
    check_eq("flush_pc", out_pc, BASE);

    // End of segment
    cycle(0, 1, 32'h0040_03F8, 1);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);
    check_eq("end_pc", out_pc, 32'h0040_03FC);
    cycle(0, 0, '0, 1);
    check_eq("end_fault",    {31'd0, fault}, 32'd1);
    check_eq("end_fault_pc", fault_pc, 32'h0040_0400);
    cycle(0, 0, '0, 1);
    check_eq("end_hold", {31'd0, out_valid}, 32'd0);

    // Misaligned and low redirects
    cycle(0, 1, 32'h0040_0002, 1);
    cycle(0, 0, '0, 1);
    check_eq("mis_fault_pc", fault_pc, 32'h0040_0002);
    cycle(0, 1, 32'h0000_0000, 0);
    cycle(0, 0, '0, 0);
    check_eq("low_fault_pc", fault_pc, 32'h0000_0000);
    cycle(0, 1, BASE, 1);
    check_eq("resume_fault", {31'd0, fault}, 32'd0);
    cycle(0, 0, '0, 1);
    check_eq("resume_pc", out_pc, BASE);

    // Clear while faulted with five counted words
    cycle(1, 0, '0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1);
    cycle(0, 1, 32'h0000_0000, 1);
    cycle(0, 0, '0, 1);
    check_eq("pre_clr_count", fetch_count, 32'd5);
    cycle(1, 1, 32'h1234_5678, 1);
    check_eq("clr_addr", imem_addr, 32'h0040_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic clr, rv, rdy;
      clr = ($urandom_range(99, 0) < 1);
      rv  = ($urandom_range(99, 0) < 6);
      rdy = ($urandom_range(99, 0) < 70);
      cycle(clr, rv, rv ? pick_target() : $urandom, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
# instruction_fetch_controller

Sequences the single-cycle instruction memory. It owns the program counter, drives the memory fetch address, and registers each returned word into a one-entry output stage. A valid/ready handshake delivers the word to decode. The block also applies branch/jump redirects, detects fetches outside the text segment or misaligned fetches, and counts delivered instructions.

## Interface
- RESET_PC, 32'h00400000, PC value loaded on clear
- TEXT_BASE, 32'h00400000, first legal fetch address (inclusive)
- TEXT_LIMIT, 32'h00400400, end of text segment (exclusive; 256 words)
- clock  input  1  single clock; all state updates on posedge
- clear  input  1  synchronous, active-high reset
- imem_addr  output  32  fetch address to instruction memory; equals current PC, combinational from the PC register
- imem_instr  input  32  instruction word returned combinationally by memory for imem_addr, same cycle
- redirect_valid  input  1  load a new PC this cycle (branch/jump taken)
- redirect_target  input  32  new PC when redirect_valid=1
- out_valid  output  1  out_instr/out_pc hold a fetched instruction
- out_ready  input  1  decode accepts the output this cycle
- out_instr  output  32  fetched instruction word
- out_pc  output  32  address the word was fetched from
- fault  output  1  fetch halted on an illegal PC
- fault_pc  output  32  offending PC, latched on entry to FAULT
- fetch_count  output  32  number of completed output handshakes

## Operation
- FSM states are FETCH and FAULT. Reset state is FETCH.
- Legal PC: TEXT_BASE <= pc < TEXT_LIMIT and pc[1:0]==0. Comparisons are unsigned on 32 bits.
- Output stage is "free" when out_valid==0 or out_ready==1.
- Per-cycle priority is clear, then redirect, then FETCH/FAULT action.
  - clear has top priority.
  - On redirect_valid=1 (any state):
    - pc <= redirect_target.
    - out_valid <= 0, even if out_ready=1 this cycle. The flushed word is not counted.
    - State <= FETCH, fault <= 0. fault_pc keeps its value.
    - No fetch is loaded this cycle.
  - In FETCH, no redirect, stage free, PC legal:
    - out_instr <= imem_instr, out_pc <= pc, out_valid <= 1.
    - pc <= pc + 4, with 32-bit wrap.
  - In FETCH, no redirect, stage free, PC illegal:
    - State <= FAULT, fault <= 1, fault_pc <= pc.
    - out_valid <= 0 (the stage was free). pc unchanged.
  - In FETCH, no redirect, stage not free (out_valid=1, out_ready=0):
    - Hold pc and all out_* stable. The legality check is deferred.
  - In FAULT, no redirect: hold everything. out_valid stays 0. Only redirect or clear exits.
- fetch_count increments by 1 on every cycle with out_valid & out_ready and no redirect. It wraps from 0xFFFFFFFF to 0.
- A handshake plus a new load in the same cycle is allowed. It counts the old word and loads the next one, giving back-to-back delivery.
- A misaligned redirect_target is accepted into pc. It then faults on the following FETCH cycle.

## Timing
- Reset values after a clock edge with clear=1:
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0.
  - fault=0, fault_pc=0, fetch_count=0. State FETCH.
- First out_valid=1 occurs at the first edge after clear deasserts (1-cycle latency from PC to output).
- Throughput is one instruction per cycle while out_ready=1 and the PC stays legal.
- Redirect bubble: the edge with redirect_valid=1 clears out_valid. The target's word appears at the next edge, so redirect-to-output latency is 2 edges.
- Fault: fault rises at the edge where the illegal PC would have loaded.
- clear mid-stall or mid-fault returns to reset values at that edge, regardless of other inputs.
- out_* must not change while out_valid=1 and out_ready=0, unless redirect or clear is asserted.

## Test plan
- Sequential fetch: memory holds 0x00221820 at 0x00400000 and 0x00221822 at 0x00400004; out_ready=1 after clear. Expect out_pc 0x00400000 then 0x00400004, instrs in order, fetch_count=2 after two handshakes.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1. Expect out_instr/out_pc/imem_addr unchanged and fetch_count unchanged; release gives exactly one count per word.
- Redirect flush: redirect_valid=1 to 0x00400000 while out_valid=1 and out_ready=1. Expect out_valid=0 next edge, no count, and the word at 0x00400000 one edge later.
- End of segment: run to pc=0x004003FC. Expect that word delivered, then fault=1, fault_pc=0x00400400, out_valid=0 held.
- Misaligned or low redirect: redirect to 0x00400002, then separately to 0x00000000. Expect fault=1 with fault_pc equal to the target; a later redirect to 0x00400000 clears fault and resumes fetch.
- Reset mid-operation: assert clear while in FAULT with fetch_count=5. Expect all outputs at reset values and imem_addr=0x00400000 at the next edge.
